sw_debounce: RTL

Conditions the raw slide-switch inputs before they reach the Nios II input PIO (pio_0). Each bit is synchronised to CLK, then debounced: a new level is accepted only after it has been stable for a programmable number of cycles. The block also produces one-cycle rise/fall pulses and a sticky event flag with acknowledge, so software can poll for switch changes. One instance sits between the board switch pins and the Qsys system's pio_0 export.

---
 rtl/sw_debounce_pkg.sv | 13 +
 rtl/sw_debounce_if.sv | 32 +++
 rtl/sw_debounce_bit.sv | 70 +++++++
 rtl/sw_debounce.sv | 61 ++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
// Imported by the per-bit filter and the top level.
package sw_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int CLK_HZ                  = 50000000;

  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch-conditioning bundle: raw pins and ack in,
// debounced level, edge pulses and sticky event out.
interface sw_debounce_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             evt;
  logic             ack;

  modport master (
    output raw,
    output ack,
    input  stable,
    input  rise,
    input  fall,
    input  evt
  );

  modport slave (
    input  raw,
    input  ack,
    output stable,
    output rise,
    output fall,
    output evt
  );

endinterface

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchroniser chain, stability counter,
// debounced level and registered rise/fall pulses.
module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw};
    sync     = sync_q[SYNC_STAGES-1];
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    accept   = 1'b0;
    // Any return to the stable level leaves cnt_d at zero.
    if (sync != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        accept   = 1'b1;
        stable_d = sync;
        rise_d   = sync;
        fall_d   = ~sync;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH slide switches for pio_0 and keeps a
// sticky change flag that software clears with an ack.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] Sw_raw,
  output logic [WIDTH-1:0] Sw_stable,
  output logic [WIDTH-1:0] Sw_rise,
  output logic [WIDTH-1:0] Sw_fall,
  output logic             Sw_event,
  input  logic             Sw_event_ack
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] accept;
  logic             event_q, event_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk    (CLK),
      .rst    (RST),
      .raw    (Sw_raw[i]),
      .stable (Sw_stable[i]),
      .rise   (Sw_rise[i]),
      .fall   (Sw_fall[i]),
      .accept (accept[i])
    );
  end

  // A new acceptance beats a simultaneous ack.
  always_comb begin
    event_d = event_q;
    if (|accept) begin
      event_d = 1'b1;
    end else if (Sw_event_ack) begin
      event_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      event_q <= 1'b0;
    end else begin
      event_q <= event_d;
    end
  end

  assign Sw_event = event_q;

endmodule
